// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code counter slice: direction encoding and default width.
package gray_pkg;

  localparam int   DEFAULT_WIDTH = 8;
  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;

endpackage : gray_pkg

// File: rtl/gray_counter_if.sv
// Control and status bundle between a counter user (master) and the Gray counter (slave).
interface gray_counter_if
  import gray_pkg::*;
#(
  parameter int bit_width = DEFAULT_WIDTH
) ();

  logic                 en;
  logic                 dir;
  logic                 load;
  logic [bit_width-1:0] load_bin;
  logic [bit_width-1:0] bin_out;
  logic [bit_width-1:0] gray_out;
  logic                 wrap;
  logic                 at_max;
  logic                 at_min;

  modport master (
    output en, dir, load, load_bin,
    input  bin_out, gray_out, wrap, at_max, at_min
  );

  modport slave (
    input  en, dir, load, load_bin,
    output bin_out, gray_out, wrap, at_max, at_min
  );

endinterface : gray_counter_if

// File: rtl/gray_counter_bin2gray.sv
// Combinational binary-to-reflected-Gray encoder.
module bin2gray #(
  parameter int width = 8
) (
  input  logic [width-1:0] bin,
  output logic [width-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule : bin2gray

// File: rtl/gray_counter.sv
// Up/down binary counter with a separately registered Gray-code copy, load, and wrap/saturate limits.
module gray_counter
  import gray_pkg::*;
#(
  parameter int bit_width = DEFAULT_WIDTH,
  parameter bit sat_mode  = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_counter_if.slave  bus
);

  logic [bit_width-1:0] bin_q, bin_nxt;
  logic [bit_width-1:0] gray_q, gray_nxt;
  logic                 wrap_q, wrap_nxt;
  logic                 at_max, at_min;

  // Limit flags decode the register only, so no input reaches them combinationally.
  assign at_max = (bin_q == {bit_width{1'b1}});
  assign at_min = (bin_q == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (bus.load) begin
      bin_nxt = bus.load_bin;
    end else if (bus.en) begin
      if (bus.dir == DIR_UP) begin
        if (!at_max) begin
          bin_nxt = bin_q + 1'b1;
        end else if (!sat_mode) begin
          bin_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_min) begin
          bin_nxt = bin_q - 1'b1;
        end else if (!sat_mode) begin
          bin_nxt  = {bit_width{1'b1}};
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Gray register is loaded from the encoded next value, keeping both copies in step.
  bin2gray #(.width(bit_width)) u_bin2gray (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_max   = at_max;
  assign bus.at_min   = at_min;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: one wrapping and one saturating 8-bit instance.
module tb_gray_counter;
  import gray_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  gray_counter_if #(.bit_width(8)) bus0 ();
  gray_counter_if #(.bit_width(8)) bus1 ();

  gray_counter #(.bit_width(8), .sat_mode(1'b0)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  gray_counter #(.bit_width(8), .sat_mode(1'b1)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Independent Gray-to-binary decode used to confirm gray_out tracks bin_out.
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One clock, then settle 1 time unit past the edge before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] prev_gray;
    logic [7:0] exp_bin;

    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    {bus0.en, bus0.dir, bus0.load, bus0.load_bin} = {1'b0, DIR_UP, 1'b0, 8'h00};
    {bus1.en, bus1.dir, bus1.load, bus1.load_bin} = {1'b0, DIR_UP, 1'b0, 8'h00};
    step();
    step();

    // Reset state on both instances
    check8("rst bin0",  bus0.bin_out,  8'h00);
    check8("rst gray0", bus0.gray_out, 8'h00);
    check1("rst wrap0", bus0.wrap,     1'b0);
    check1("rst min0",  bus0.at_min,   1'b1);
    check1("rst max0",  bus0.at_max,   1'b0);
    check8("rst bin1",  bus1.bin_out,  8'h00);
    check1("rst min1",  bus1.at_min,   1'b1);

    // Free-running up count through a full wrap: values 0..255 then 0..3
    rst_n    = 1'b1;
    bus0.en  = 1'b1;
    bus0.dir = DIR_UP;
    prev_gray = bus0.gray_out;
    for (int k = 1; k <= 259; k++) begin
      step();
      exp_bin = 8'(k % 256);
      check8("run bin",   bus0.bin_out, exp_bin);
      check8("run gray",  bus0.gray_out, exp_bin ^ (exp_bin >> 1));
      check8("run g2b",   g2b(bus0.gray_out), exp_bin);
      check1("run wrap",  bus0.wrap, (k == 256));
      check1("run max",   bus0.at_max, (k == 255));
      check1("run 1bit",  ($countones(bus0.gray_out ^ prev_gray) == 1), 1'b1);
      prev_gray = bus0.gray_out;
    end

    // Load wins over en
    bus0.load     = 1'b1;
    bus0.load_bin = 8'hA5;
    step();
    check8("load bin",  bus0.bin_out,  8'hA5);
    check8("load gray", bus0.gray_out, 8'hF7);
    check1("load wrap", bus0.wrap,     1'b0);

    // Down from zero wraps to max, then immediate up wraps back
    bus0.load_bin = 8'h00;
    step();
    check8("load0 bin", bus0.bin_out, 8'h00);
    bus0.load = 1'b0;
    bus0.dir  = DIR_DOWN;
    prev_gray = bus0.gray_out;
    step();
    check8("dnwrap bin",  bus0.bin_out,  8'hFF);
    check8("dnwrap gray", bus0.gray_out, 8'h80);
    check1("dnwrap wrap", bus0.wrap,     1'b1);
    check1("dnwrap 1bit", ($countones(bus0.gray_out ^ prev_gray) == 1), 1'b1);
    check1("dnwrap max",  bus0.at_max,   1'b1);
    bus0.dir = DIR_UP;
    step();
    check8("upwrap bin",  bus0.bin_out,  8'h00);
    check8("upwrap gray", bus0.gray_out, 8'h00);
    check1("upwrap wrap", bus0.wrap,     1'b1);

    // Hold with en low: value kept, wrap drops
    bus0.en = 1'b0;
    step();
    check8("hold bin",  bus0.bin_out, 8'h00);
    check1("hold wrap", bus0.wrap,    1'b0);

    // Direction reversal with no dead cycle
    bus0.load     = 1'b1;
    bus0.load_bin = 8'h10;
    step();
    bus0.load = 1'b0;
    bus0.en   = 1'b1;
    step();
    check8("rev up",   bus0.bin_out, 8'h11);
    bus0.dir = DIR_DOWN;
    step();
    check8("rev dn",   bus0.bin_out, 8'h10);
    check8("rev gray", bus0.gray_out, 8'h18);
    step();
    check8("rev dn2",  bus0.bin_out, 8'h0F);

    // Reset overrides simultaneous load and en mid-count
    bus0.load     = 1'b1;
    bus0.load_bin = 8'h40;
    bus0.en       = 1'b0;
    step();
    check8("pre-rst bin", bus0.bin_out, 8'h40);
    bus0.en       = 1'b1;
    bus0.load_bin = 8'h77;
    rst_n         = 1'b0;
    step();
    check8("midrst bin",  bus0.bin_out,  8'h00);
    check8("midrst gray", bus0.gray_out, 8'h00);
    check1("midrst wrap", bus0.wrap,     1'b0);
    check1("midrst min",  bus0.at_min,   1'b1);
    rst_n     = 1'b1;
    bus0.load = 1'b0;
    bus0.dir  = DIR_UP;
    step();
    check8("resume bin", bus0.bin_out, 8'h01);
    check8("resume g2b", g2b(bus0.gray_out), 8'h01);
    bus0.en = 1'b0;

    // Saturating instance: up against the top
    bus1.load     = 1'b1;
    bus1.load_bin = 8'hFE;
    step();
    bus1.load = 1'b0;
    bus1.en   = 1'b1;
    bus1.dir  = DIR_UP;
    for (int k = 0; k < 3; k++) begin
      step();
      check8("sat up bin",  bus1.bin_out,  8'hFF);
      check8("sat up gray", bus1.gray_out, 8'h80);
      check1("sat up max",  bus1.at_max,   1'b1);
      check1("sat up wrap", bus1.wrap,     1'b0);
    end

    // Saturating instance: down against the bottom
    bus1.load     = 1'b1;
    bus1.load_bin = 8'h01;
    step();
    bus1.load = 1'b0;
    bus1.dir  = DIR_DOWN;
    for (int k = 0; k < 3; k++) begin
      step();
      check8("sat dn bin",  bus1.bin_out, 8'h00);
      check1("sat dn min",  bus1.at_min,  1'b1);
      check1("sat dn wrap", bus1.wrap,    1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_gray_counter

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter bit_width, default 8; counter width in bits, legal range 2..32.
REQ-002 Parameter sat_mode, default 0; 0 means wrap at the count limits, 1 means saturate at the count limits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 dir  input  1  count direction; 0 counts up, 1 counts down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_bin  input  bit_width  binary value captured when load is high.
REQ-009 bin_out  output  bit_width  registered binary count.
REQ-010 gray_out  output  bit_width  registered Gray-code count, directly consumable by the gray-to-binary stage.
REQ-011 wrap  output  1  registered one-cycle pulse flagging a wrap-around step.
REQ-012 at_max  output  1  high when bin_out equals all ones.
REQ-013 at_min  output  1  high when bin_out equals zero.

Function
REQ-014 Update priority at each rising edge SHALL be: reset, then load, then en, then hold.
REQ-015 load=1: bin_out SHALL become load_bin and gray_out SHALL become load_bin ^ (load_bin >> 1) on the next edge; wrap SHALL be 0; en and dir SHALL be ignored.
REQ-016 en=1, load=0, dir=0, bin_out not at_max: bin_out SHALL increment by 1 modulo 2^bit_width.
REQ-017 en=1, load=0, dir=1, bin_out not at_min: bin_out SHALL decrement by 1.
REQ-018 A limit step is up at at_max or down at at_min.
REQ-019 Limit step with sat_mode=0: the count SHALL wrap (max->0 or 0->max) and wrap SHALL be 1 for exactly that following cycle.
REQ-020 Limit step with sat_mode=1: the count SHALL hold and wrap SHALL stay 0.
REQ-021 gray_out SHALL be its own register, loaded with the Gray encoding of the next binary value; it SHALL never be decoded combinationally from bin_out after the register.
REQ-022 Latency: bin_out and gray_out SHALL reflect a load or step on the cycle after the sampling edge; both SHALL always be mutually consistent.
REQ-023 Across any single en step, including a wrap, gray_out SHALL change in exactly one bit position.
REQ-024 en=0 and load=0: all registers SHALL hold and wrap SHALL be 0.
REQ-025 at_max and at_min SHALL be combinational decodes of the bin_out register only, with no input-to-output path.
REQ-026 A dir change between consecutive enabled cycles SHALL take effect immediately, with no dead cycle.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set bin_out=0, gray_out=0 and wrap=0, which gives at_min=1 and at_max=0.
REQ-028 Reset SHALL override a simultaneous load or en, including mid-count; counting SHALL resume from 0 on the first edge with rst_n=1.
REQ-029 Outputs before the first reset edge are undefined; the bench SHALL NOT check them.

Structure
REQ-030 Shared package gray_pkg SHALL hold the DIR_UP=0 and DIR_DOWN=1 constants and the default width constant.
REQ-031 The next-state Gray encoding SHALL be produced by one instance of the existing bin2gray sub-module fed with the next binary value; no other sub-modules.
REQ-032 The implementation SHALL use a single always block for the registers plus combinational next-state logic, with no latches.

Verification
REQ-033 Reset, then en=1, dir=0 for 260 cycles at bit_width=8, sat_mode=0 -> bin_out runs 0..255 then 0..3; wrap is high only on the cycle bin_out=0 after 255; every step changes exactly one bit of gray_out.
REQ-034 load=1 with load_bin=8'hA5 and en=1 -> next cycle bin_out=8'hA5, gray_out=8'hF7, wrap=0.
REQ-035 sat_mode=1: load 8'hFE, then up for 3 cycles -> bin_out reads FF, FF, FF; at_max=1; wrap never asserted. Then down from 8'h01 for 3 cycles -> bin_out reads 00, 00, 00; at_min=1.
REQ-036 sat_mode=0: load 8'h00, en=1, dir=1 -> bin_out=8'hFF, gray_out=8'h80, wrap=1 for one cycle. Then dir=0 on the next cycle -> bin_out=8'h00, wrap=1.
REQ-037 rst_n=0 with load=1 and en=1 at count 8'h40 -> next cycle bin_out=0, gray_out=0, wrap=0. Feeding gray_out to the gray-to-binary stage always reproduces bin_out.
